// File: rtl/riscv_pkg.sv
// Shared RV32I fetch definitions: opcode constants, the NOP encoding and the
// fetch FSM state type used by instr_fetch_unit.
package riscv_pkg;

    localparam logic [6:0]  OP_LW     = 7'b0000011;
    localparam logic [6:0]  OP_SW     = 7'b0100011;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_BEQ    = 7'b1100011;

    // addi x0,x0,0 -- presented before the first fetch completes
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EXEC
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with next-PC selection between the sequential
// address and a word-aligned branch target.
module fetch_pc_reg
    import riscv_pkg::*;
#(
    parameter int unsigned            XLEN     = 32,
    parameter logic [XLEN-1:0]        RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4
);

    localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] pc_next;

    // Sequential address wraps naturally at 2^XLEN; targets lose their low two bits
    always_comb begin
        pc_plus4 = pc + FOUR;
        pc_next  = pc_src ? (pc_target & WORD_MASK) : pc_plus4;
    end

    // PC only moves when the executing instruction retires
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory,
// instruction register and decode-field slicing for the control unit.
// Optional retired-instruction counter enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             PCSrc,
    input  logic [XLEN-1:0]  pc_target,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [6:0]       op,
    output logic [2:0]       funct3,
    output logic             funct7_bit5,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_retired
`endif
);

    fetch_state_t state;
    logic         advance;

    // An instruction retires on any unstalled EXEC cycle
    always_comb begin
        advance = (state == EXEC) && !stall;
    end

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .pc_src    (PCSrc),
        .pc_target (pc_target),
        .pc        (pc),
        .pc_plus4  (pc_plus4)
    );

    // Fetch FSM with registered req/valid and the instruction register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= INSTR_NOP;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        state       <= REQ;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    // Fetch address is the PC itself; decode fields are plain slices of instr
    always_comb begin
        imem_addr   = pc;
        op          = instr[6:0];
        funct3      = instr[14:12];
        funct7_bit5 = instr[30];
        rs1         = instr[19:15];
        rs2         = instr[24:20];
        rd          = instr[11:7];
    end

`ifdef FETCH_PERF_CNT_EN
    // Retired-instruction counter, wraps at 2^CNT_W
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_retired <= '0;
        end else if (advance) begin
            perf_retired <= perf_retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// transaction-level model. Perf counter checks follow FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrc;
    logic [31:0] pc_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7_bit5;
    logic [4:0]  rs1, rs2, rd;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_retired;
`endif

    // Second instance with a top-of-memory reset PC for the wrap case
    logic        rst_h_n;
    logic        req_h;
    logic [31:0] addr_h;
    logic        valid_h;
    logic [31:0] instr_h, pc_h, pc_plus4_h;
    logic [6:0]  op_h;
    logic [2:0]  funct3_h;
    logic        f7_h;
    logic [4:0]  rs1_h, rs2_h, rd_h;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_h;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Model state: a fetch is outstanding, an instruction is held, or the
    // unit is in its one dead cycle after reset
    logic        m_known = 1'b0;
    logic        m_boot, m_wait, m_have;
    logic [31:0] m_pc, m_instr, m_ret;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .PCSrc        (PCSrc),
        .pc_target    (pc_target),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .op           (op),
        .funct3       (funct3),
        .funct7_bit5  (funct7_bit5),
        .rs1          (rs1),
        .rs2          (rs2),
        .rd           (rd)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_retired (perf_retired)
`endif
    );

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hFFFF_FFFC),
        .CNT_W    (32)
    ) dut_hi (
        .clk          (clk),
        .rst_n        (rst_h_n),
        .imem_req     (req_h),
        .imem_addr    (addr_h),
        .imem_ack     (1'b1),
        .imem_rdata   (32'h0000_0013),
        .stall        (1'b0),
        .PCSrc        (1'b0),
        .pc_target    (32'h0000_0000),
        .instr_valid  (valid_h),
        .instr        (instr_h),
        .pc           (pc_h),
        .pc_plus4     (pc_plus4_h),
        .op           (op_h),
        .funct3       (funct3_h),
        .funct7_bit5  (f7_h),
        .rs1          (rs1_h),
        .rs2          (rs2_h),
        .rd           (rd_h)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_retired (perf_h)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; the model applies the rules to the inputs as they
    // stand at the edge
    task automatic step();
        logic        nb, nw, nh, was_rst;
        logic [31:0] np, ni, nr;
        nb = m_boot; nw = m_wait; nh = m_have;
        np = m_pc;   ni = m_instr; nr = m_ret;
        was_rst = !rst_n;
        if (!rst_n) begin
            nb = 1'b1; nw = 1'b0; nh = 1'b0;
            np = 32'h0; ni = 32'h0000_0013; nr = 32'h0;
        end else if (m_boot) begin
            nb = 1'b0; nw = 1'b1;
        end else if (m_wait) begin
            if (imem_ack) begin
                ni = imem_rdata; nh = 1'b1; nw = 1'b0;
            end
        end else if (m_have && !stall) begin
            nr = m_ret + 32'd1;
            np = PCSrc ? (pc_target & 32'hFFFF_FFFC) : (m_pc + 32'd4);
            nh = 1'b0; nw = 1'b1;
        end
        @(posedge clk);
        #1;
        m_boot = nb; m_wait = nw; m_have = nh;
        m_pc = np; m_instr = ni; m_ret = nr;
        if (was_rst) m_known = 1'b1;
    endtask

    task automatic steps(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    // Every cycle: all outputs of the main instance against the model
    always @(negedge clk) begin
        if (m_known) begin
            chk("req",      32'(imem_req),    32'(m_wait));
            chk("addr",     imem_addr,        m_pc);
            chk("valid",    32'(instr_valid), 32'(m_have));
            chk("instr",    instr,            m_instr);
            chk("pc",       pc,               m_pc);
            chk("pc_plus4", pc_plus4,         m_pc + 32'd4);
            chk("op",       32'(op),          32'(m_instr[6:0]));
            chk("funct3",   32'(funct3),      32'(m_instr[14:12]));
            chk("f7b5",     32'(funct7_bit5), 32'(m_instr[30]));
            chk("rs1",      32'(rs1),         32'(m_instr[19:15]));
            chk("rs2",      32'(rs2),         32'(m_instr[24:20]));
            chk("rd",       32'(rd),          32'(m_instr[11:7]));
`ifdef FETCH_PERF_CNT_EN
            chk("perf",     perf_retired,     m_ret);
`endif
        end
    end

    initial begin
        rst_n = 1'b0; rst_h_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        PCSrc = 1'b0; pc_target = 32'h0;

        // Wrap instance: reset PC at the top of the address space
        steps(2);
        chk("hi_rst_req",  32'(req_h),  32'h0);
        chk("hi_rst_addr", addr_h,      32'hFFFF_FFFC);
        chk("hi_rst_p4",   pc_plus4_h,  32'h0000_0000);
        rst_h_n = 1'b1;
        step();
        chk("hi_req",      32'(req_h),  32'h1);
        chk("hi_addr",     addr_h,      32'hFFFF_FFFC);
        step();
        chk("hi_valid",    32'(valid_h), 32'h1);
        step();
        chk("hi_wrap_req", 32'(req_h),  32'h1);
        chk("hi_wrap",     addr_h,      32'h0000_0000);

        // 1. reset and the IDLE cycle
        chk("t1_req",   32'(imem_req),    32'h0);
        chk("t1_pc",    pc,               32'h0);
        chk("t1_valid", 32'(instr_valid), 32'h0);
        chk("t1_instr", instr,            32'h0000_0013);
        rst_n = 1'b1;
        #1 chk("t1_idle", 32'(imem_req),  32'h0);
        step();
        chk("t1_req1",  32'(imem_req),    32'h1);
        chk("t1_addr",  imem_addr,        32'h0);

        // 2. zero-wait lw
        imem_ack = 1'b1; imem_rdata = 32'h3E80_2403;
        step();
        imem_ack = 1'b0;
        chk("t2_valid", 32'(instr_valid), 32'h1);
        chk("t2_op",    32'(op),          32'h03);
        chk("t2_f3",    32'(funct3),      32'h2);
        chk("t2_rd",    32'(rd),          32'd8);
        chk("t2_rs1",   32'(rs1),         32'd0);
        step();
        chk("t2_addr",  imem_addr,        32'h4);

        // 3. three wait states on add
        imem_rdata = 32'h0094_0533;
        steps(3);
        chk("t3_req",   32'(imem_req),    32'h1);
        chk("t3_addr",  imem_addr,        32'h4);
        chk("t3_valid", 32'(instr_valid), 32'h0);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        chk("t3_op",    32'(op),          32'h33);
        chk("t3_f3",    32'(funct3),      32'h0);
        chk("t3_f7",    32'(funct7_bit5), 32'h0);
        chk("t3_rd",    32'(rd),          32'd10);
        step();
        chk("t3_addr8", imem_addr,        32'h8);

        // 4. taken branch, aligned and misaligned target
        imem_ack = 1'b1; imem_rdata = 32'h0000_0463;
        step();
        chk("t4_op",    32'(op),          32'h63);
        PCSrc = 1'b1; pc_target = 32'h10;
        step();
        chk("t4_tgt",   imem_addr,        32'h10);
        step();
        pc_target = 32'h13;
        step();
        chk("t4_mis",   imem_addr,        32'h10);
        PCSrc = 1'b0; pc_target = 32'h0;

        // 5. stall, then reset while waiting for an ack
        step();
        stall = 1'b1; imem_ack = 1'b0;
        steps(2);
        chk("t5_pc",    pc,               32'h10);
        chk("t5_req",   32'(imem_req),    32'h0);
        chk("t5_valid", 32'(instr_valid), 32'h1);
        stall = 1'b0;
        step();
        chk("t5_adv",   imem_addr,        32'h14);
        step();
        rst_n = 1'b0;
        step();
        chk("t5_rreq",  32'(imem_req),    32'h0);
        chk("t5_rpc",   pc,               32'h0);
        rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        chk("t5_ign",   32'(instr_valid), 32'h0);
        chk("t5_ignI",  instr,            32'h0000_0013);

        // 6. five unstalled retires
        steps(10);
`ifdef FETCH_PERF_CNT_EN
        chk("t6_perf",  perf_retired,     32'd5);
`endif
        chk("t6_addr",  imem_addr,        32'd20);

        // Randomized traffic
        for (int unsigned i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(99) != 0);
            imem_ack   = ($urandom_range(1) != 0);
            imem_rdata = $urandom;
            stall      = ($urandom_range(9) < 3);
            PCSrc      = ($urandom_range(9) < 3);
            pc_target  = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
